// File: rtl/opb_pkg.sv
// Shared definitions for the OPB master arbiter: FSM encoding, bus widths,
// CAN region defaults, read latencies and the region-membership helper.
package opb_pkg;

  localparam int OPB_DW = 32;
  localparam int OPB_AW = 32;

  localparam logic [OPB_AW-1:0] CAN_BASE_DEF = 32'h0000_9000;
  localparam logic [OPB_AW-1:0] CAN_SIZE_DEF = 32'h0000_1000;

  localparam logic [1:0] LAT_STD = 2'd1;
  localparam logic [1:0] LAT_CAN = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  typedef struct packed {
    state_t     state;
    logic [1:0] ptr;
  } dbg_t;

  // Subtracting first keeps the upper bound from wrapping at the top of the map.
  function automatic logic in_region(input logic [OPB_AW-1:0] addr,
                                     input logic [OPB_AW-1:0] base,
                                     input logic [OPB_AW-1:0] size);
    return (addr >= base) && ((addr - base) < size);
  endfunction

endpackage

// File: rtl/opb_master_arbiter_if.sv
// Requester and OPB master-port signals of the arbiter, grouped in one bundle.
// Handshake: a requester raises M_REQ with M_WR/M_ADDR/M_WDATA stable and holds it until its one-cycle M_ACK; it drops M_REQ at the edge ending the ACK cycle.
interface opb_master_arbiter_if #(
  parameter int N_MASTERS = 2
);
  logic [N_MASTERS-1:0]    M_REQ;
  logic [N_MASTERS-1:0]    M_WR;
  logic [32*N_MASTERS-1:0] M_ADDR;
  logic [32*N_MASTERS-1:0] M_WDATA;
  logic [N_MASTERS-1:0]    M_ACK;
  logic [31:0]             M_RDATA;
  logic [N_MASTERS-1:0]    GRANT;
  logic                    BUSY;
  logic                    OPB_RE;
  logic                    OPB_WE;
  logic [31:0]             OPB_ADDR;
  logic [31:0]             OPB_DI;
  logic [31:0]             OPB_DO;

  modport master (
    input  M_REQ, M_WR, M_ADDR, M_WDATA, OPB_DO,
    output M_ACK, M_RDATA, GRANT, BUSY, OPB_RE, OPB_WE, OPB_ADDR, OPB_DI
  );

  modport slave (
    output M_REQ, M_WR, M_ADDR, M_WDATA, OPB_DO,
    input  M_ACK, M_RDATA, GRANT, BUSY, OPB_RE, OPB_WE, OPB_ADDR, OPB_DI
  );
endinterface

// File: rtl/rr_arbiter.sv
// N-input round-robin arbiter: combinational one-hot grant searched from the
// pointer; the pointer moves past the winner when advance is asserted.
module rr_arbiter #(
  parameter int N  = 2,
  parameter int PW = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  req,
  input  logic          advance,
  output logic [N-1:0]  grant,
  output logic [PW-1:0] ptr
);

  logic [PW-1:0] nxt_ptr;
  logic          found;

  always_comb begin
    grant   = '0;
    nxt_ptr = ptr;
    found   = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!found && req[(int'(ptr) + i) % N]) begin
        grant[(int'(ptr) + i) % N] = 1'b1;
        nxt_ptr = PW'((int'(ptr) + i + 1) % N);
        found   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (advance && found) begin
      ptr <= nxt_ptr;
    end
  end

endmodule

// File: rtl/opb_master_arbiter.sv
// Arbitrates N requesters onto one OPB master port, issuing single-cycle
// strobes and capturing read data at a region-dependent latency.
module opb_master_arbiter
  import opb_pkg::*;
#(
  parameter int          N_MASTERS = 2,
  parameter logic [31:0] CAN_BASE  = CAN_BASE_DEF,
  parameter logic [31:0] CAN_SIZE  = CAN_SIZE_DEF
) (
  input  logic                 OPB_CLK,
  input  logic                 OPB_RST_N,
  opb_master_arbiter_if.master bus,
  output dbg_t                 dbg
);

  localparam int PW = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;

  state_t               state;
  logic                 wr_q;
  logic [1:0]           lat_cnt;
  logic [N_MASTERS-1:0] arb_grant;
  logic [PW-1:0]        arb_ptr;
  logic [PW-1:0]        win_idx;
  logic                 advance;

  assign advance = (state == ST_IDLE) && (|bus.M_REQ);

  rr_arbiter #(.N(N_MASTERS), .PW(PW)) u_rr (
    .clk     (OPB_CLK),
    .rst_n   (OPB_RST_N),
    .req     (bus.M_REQ),
    .advance (advance),
    .grant   (arb_grant),
    .ptr     (arb_ptr)
  );

  always_comb begin
    win_idx = '0;
    for (int i = 0; i < N_MASTERS; i++) begin
      if (arb_grant[i]) win_idx = PW'(i);
    end
  end

  assign dbg.state = state;
  assign dbg.ptr   = 2'(arb_ptr);

  always_ff @(posedge OPB_CLK or negedge OPB_RST_N) begin
    if (!OPB_RST_N) begin
      state        <= ST_IDLE;
      wr_q         <= 1'b0;
      lat_cnt      <= '0;
      bus.GRANT    <= '0;
      bus.M_ACK    <= '0;
      bus.BUSY     <= 1'b0;
      bus.OPB_RE   <= 1'b0;
      bus.OPB_WE   <= 1'b0;
      bus.OPB_ADDR <= '0;
      bus.OPB_DI   <= '0;
      bus.M_RDATA  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (advance) begin
            bus.GRANT    <= arb_grant;
            bus.OPB_ADDR <= bus.M_ADDR[32*win_idx +: 32];
            bus.OPB_DI   <= bus.M_WDATA[32*win_idx +: 32];
            wr_q         <= bus.M_WR[win_idx];
            // Strobes are registered here so they are high only during ISSUE.
            bus.OPB_RE   <= !bus.M_WR[win_idx];
            bus.OPB_WE   <= bus.M_WR[win_idx];
            bus.BUSY     <= 1'b1;
            state        <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          bus.OPB_RE <= 1'b0;
          bus.OPB_WE <= 1'b0;
          if (wr_q) begin
            bus.M_ACK <= bus.GRANT;
            state     <= ST_DONE;
          end else begin
            lat_cnt <= in_region(bus.OPB_ADDR, CAN_BASE, CAN_SIZE) ? LAT_CAN : LAT_STD;
            state   <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (lat_cnt == LAT_STD) begin
            bus.M_RDATA <= bus.OPB_DO;
            bus.M_ACK   <= bus.GRANT;
            state       <= ST_DONE;
          end else begin
            lat_cnt <= lat_cnt - 2'd1;
          end
        end
        ST_DONE: begin
          bus.M_ACK <= '0;
          bus.GRANT <= '0;
          bus.BUSY  <= 1'b0;
          state     <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_opb_master_arbiter.sv
// Bench for opb_master_arbiter: directed vector table, contention and reset
// sequences, then randomized traffic against a transaction-level model.
module tb_opb_master_arbiter;
  import opb_pkg::*;

  localparam int          N        = 2;
  localparam logic [31:0] CAN_BASE = 32'h0000_9000;
  localparam logic [31:0] CAN_SIZE = 32'h0000_1000;

  logic clk;
  logic rst_n;
  dbg_t dbg;

  opb_master_arbiter_if #(.N_MASTERS(N)) bus ();

  opb_master_arbiter #(
    .N_MASTERS (N),
    .CAN_BASE  (CAN_BASE),
    .CAN_SIZE  (CAN_SIZE)
  ) dut (
    .OPB_CLK   (clk),
    .OPB_RST_N (rst_n),
    .bus       (bus),
    .dbg       (dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_vec;
  int          n_err;
  int          ptr_m;
  logic [31:0] last_rd;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time exceeded, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic apply_reset();
    rst_n       = 1'b0;
    bus.M_REQ   = '0;
    bus.M_WR    = '0;
    bus.M_ADDR  = '0;
    bus.M_WDATA = '0;
    bus.OPB_DO  = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    ptr_m   = 0;
    last_rd = '0;
  endtask

  // ---------------- checking ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- drivers ----------------
  task automatic set_req(input int m, input logic wr, input logic [31:0] a, input logic [31:0] d);
    bus.M_REQ[m]           = 1'b1;
    bus.M_WR[m]            = wr;
    bus.M_ADDR[32*m +: 32] = a;
    bus.M_WDATA[32*m +: 32] = d;
  endtask

  function automatic int model_pick();
    for (int i = 0; i < N; i++) begin
      if (bus.M_REQ[(ptr_m + i) % N]) return (ptr_m + i) % N;
    end
    return -1;
  endfunction

  // ACK cycle number measured from the IDLE cycle that samples REQ.
  function automatic int model_lat(input logic wr, input logic [31:0] a);
    longint x, lo, hi;
    if (wr) return 2;
    x  = longint'(a);
    lo = longint'(CAN_BASE);
    hi = longint'(CAN_BASE) + longint'(CAN_SIZE);
    return (x >= lo && x < hi) ? 4 : 3;
  endfunction

  function automatic logic [31:0] rand_addr();
    case ($urandom_range(0, 5))
      0:       return CAN_BASE + ($urandom() & 32'h0000_0FFC);
      1:       return $urandom() & 32'hFFFF_FFFC;
      2:       return CAN_BASE - 32'd4;
      3:       return CAN_BASE + CAN_SIZE;
      4:       return CAN_BASE + CAN_SIZE - 32'd4;
      default: return $urandom() & 32'h0000_FFFC;
    endcase
  endfunction

  // Entered at posedge+1 of the IDLE cycle that samples REQ; returns at
  // posedge+1 of the following IDLE cycle with the winner's REQ dropped.
  task automatic do_txn(input int w, input int l, input logic [31:0] cap);
    logic        wr;
    logic [31:0] a, d;
    wr = bus.M_WR[w];
    a  = bus.M_ADDR[32*w +: 32];
    d  = bus.M_WDATA[32*w +: 32];
    bus.OPB_DO = $urandom();
    @(negedge clk);
    chk("idle_grant", 32'(bus.GRANT), 32'd0);
    chk("idle_busy", 32'(bus.BUSY), 32'd0);
    chk("idle_strobe", {30'd0, bus.OPB_RE, bus.OPB_WE}, 32'd0);
    for (int c = 1; c <= l; c++) begin
      @(posedge clk);
      #1 bus.OPB_DO = (c == l - 1) ? cap : $urandom();
      @(negedge clk);
      chk("grant", 32'(bus.GRANT), 32'(1 << w));
      chk("busy", 32'(bus.BUSY), 32'd1);
      chk("opb_re", 32'(bus.OPB_RE), 32'(c == 1 && !wr));
      chk("opb_we", 32'(bus.OPB_WE), 32'(c == 1 && wr));
      chk("m_ack", 32'(bus.M_ACK), (c == l) ? 32'(1 << w) : 32'd0);
      if (c == 1) begin
        chk("opb_addr", bus.OPB_ADDR, a);
        if (wr) chk("opb_di", bus.OPB_DI, d);
      end
      if (c == l) begin
        if (!wr) last_rd = cap;
        chk("m_rdata", bus.M_RDATA, last_rd);
      end
    end
    @(posedge clk);
    #1 bus.M_REQ[w] = 1'b0;
    ptr_m = (w + 1) % N;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    int          m;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] cap;
    int          ack_cyc;
  } vec_t;

  vec_t tab [8];

  initial begin
    int          w, l;
    int          order [4];
    logic        rwr;
    n_vec = 0;
    n_err = 0;

    tab[0] = '{0, 1'b1, 32'h0000_0004, 32'hDEAD_BEEF, 32'h0000_0000, 2};
    tab[1] = '{1, 1'b0, 32'h0000_0010, 32'h0000_0000, 32'h1234_5678, 3};
    tab[2] = '{0, 1'b0, 32'h0000_9004, 32'h0000_0000, 32'hCAFE_0001, 4};
    tab[3] = '{1, 1'b0, 32'h0000_8FFC, 32'h0000_0000, 32'h1111_0001, 3};
    tab[4] = '{0, 1'b0, 32'h0000_A000, 32'h0000_0000, 32'h2222_0002, 3};
    tab[5] = '{1, 1'b0, 32'h0000_9000, 32'h0000_0000, 32'h3333_0003, 4};
    tab[6] = '{0, 1'b0, 32'h0000_9FFC, 32'h0000_0000, 32'h4444_0004, 4};
    tab[7] = '{1, 1'b1, 32'h0000_9008, 32'h5555_AAAA, 32'h0000_0000, 2};

    apply_reset();
    @(negedge clk);
    chk("rst_grant", 32'(bus.GRANT), 32'd0);
    chk("rst_busy", 32'(bus.BUSY), 32'd0);
    chk("rst_ack", 32'(bus.M_ACK), 32'd0);
    chk("rst_strobe", {30'd0, bus.OPB_RE, bus.OPB_WE}, 32'd0);
    chk("rst_addr", bus.OPB_ADDR, 32'd0);
    chk("rst_di", bus.OPB_DI, 32'd0);
    chk("rst_rdata", bus.M_RDATA, 32'd0);
    chk("rst_state", 32'(dbg.state), 32'(ST_IDLE));
    @(posedge clk);
    #1;

    foreach (tab[i]) begin
      set_req(tab[i].m, tab[i].wr, tab[i].addr, tab[i].wdata);
      do_txn(tab[i].m, tab[i].ack_cyc, tab[i].cap);
    end

    // Contention from reset: both masters keep re-requesting reads.
    apply_reset();
    order = '{0, 1, 0, 1};
    set_req(0, 1'b0, 32'h0000_0020, 32'd0);
    set_req(1, 1'b0, 32'h0000_9010, 32'd0);
    for (int k = 0; k < 4; k++) begin
      w = order[k];
      l = model_lat(1'b0, bus.M_ADDR[32*w +: 32]);
      do_txn(w, l, $urandom());
      set_req(w, 1'b0, bus.M_ADDR[32*w +: 32], 32'd0);
    end
    bus.M_REQ = '0;
    @(posedge clk);
    #1;

    // Reset in the WAIT cycle of a CAN read aborts without an ACK.
    set_req(0, 1'b0, 32'h0000_9004, 32'd0);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("pre_rst_state", 32'(dbg.state), 32'(ST_WAIT));
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_outs", {26'd0, bus.GRANT, bus.M_ACK, bus.BUSY, bus.OPB_RE}, 32'd0);
    chk("mid_rst_we", 32'(bus.OPB_WE), 32'd0);
    chk("mid_rst_addr", bus.OPB_ADDR, 32'd0);
    chk("mid_rst_rdata", bus.M_RDATA, 32'd0);
    @(posedge clk);
    #1;
    bus.M_REQ = '0;
    rst_n     = 1'b1;
    ptr_m     = 0;
    last_rd   = '0;
    @(negedge clk);
    chk("post_rst_ack", 32'(bus.M_ACK), 32'd0);
    chk("post_rst_busy", 32'(bus.BUSY), 32'd0);
    chk("post_rst_state", 32'(dbg.state), 32'(ST_IDLE));
    @(posedge clk);
    #1;

    // Randomized traffic against the round-robin / latency model.
    for (int t = 0; t < 200; t++) begin
      for (int m = 0; m < N; m++) begin
        if (!bus.M_REQ[m] && $urandom_range(0, 1) == 1) begin
          rwr = 1'($urandom_range(0, 1));
          set_req(m, rwr, rand_addr(), $urandom());
        end
      end
      if (bus.M_REQ == '0) begin
        rwr = 1'($urandom_range(0, 1));
        set_req($urandom_range(0, N - 1), rwr, rand_addr(), $urandom());
      end
      w = model_pick();
      l = model_lat(bus.M_WR[w], bus.M_ADDR[32*w +: 32]);
      do_txn(w, l, $urandom());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
